// File: rtl/latch_ctrl_pkg.sv
// Shared constants and width helpers for the latch write arbiter.
package latch_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_GATE  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Counter width able to hold the value PULSE.
   function automatic int pulse_cnt_width(input int pulse);
      return $clog2(pulse + 1);
   endfunction

   // Index width for a requester vector, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping.
module rr_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] win_onehot,
   output logic [IDXW-1:0] win_idx,
   output logic            any_req
);

   // Walk the requesters starting at ptr and keep the first one found.
   always_comb begin
      int cand;
      logic found;
      logic [IDXW-1:0] cand_idx;
      win_onehot = '0;
      win_idx    = '0;
      found      = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand     = (int'(ptr) + k) % NREQ;
         cand_idx = IDXW'(cand);
         if (!found && req[cand_idx]) begin
            found                = 1'b1;
            win_onehot[cand_idx] = 1'b1;
            win_idx              = cand_idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares one D-latch bank among NREQ requesters: round-robin grant, data
// capture, then a setup / gate pulse / hold sequence on the bank's D and C.
module latch_write_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int PULSE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done,
   output logic [WIDTH-1:0]        latch_d,
   output logic                    latch_c,
   output logic                    busy
);

   localparam int IDXW = idx_width(NREQ);
   localparam int CW   = pulse_cnt_width(PULSE);

   generate
      if (PULSE < 1) begin : g_bad_pulse
         $error("latch_write_arbiter: PULSE must be at least 1");
      end
      if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
         $error("latch_write_arbiter: NREQ must be in 2..8");
      end
   endgenerate

   logic [1:0]       state;
   logic [IDXW-1:0]  ptr;
   logic [CW-1:0]    cnt;
   logic [NREQ-1:0]  win_onehot;
   logic [IDXW-1:0]  win_idx;
   logic             any_req;
   logic [WIDTH-1:0] win_data;
   logic             start;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr (
      .req        (req),
      .ptr        (ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any_req    (any_req)
   );

   // Mux out the winner's data slice so it can be captured at grant.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_onehot[i]) begin
            win_data = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   // latch_c and done are registered from the phase, so they trail the state by
   // one edge; arbitration therefore waits until the done pulse has drained,
   // which gives the visible idle cycle between transactions.
   assign start = (state == ST_IDLE) && !(|done) && any_req;

   // Phase sequencing, pulse counting, data capture and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         cnt     <= '0;
         grant   <= '0;
         done    <= '0;
         latch_d <= '0;
         latch_c <= 1'b0;
         busy    <= 1'b0;
      end else begin
         latch_c <= (state == ST_GATE);
         done    <= (state == ST_HOLD) ? grant : '0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_SETUP;
                  grant   <= win_onehot;
                  latch_d <= win_data;
                  busy    <= 1'b1;
                  ptr     <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
               end else begin
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            ST_SETUP: begin
               state <= ST_GATE;
               cnt   <= CW'(1);
            end
            ST_GATE: begin
               if (cnt == CW'(PULSE)) begin
                  state <= ST_HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_HOLD: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed and random checks of latch_write_arbiter against a transaction-timeline model.
module tb_latch_write_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int PULSE = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      latch_d;
   logic                  latch_c;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   // Timeline model: a transaction granted at edge S shows grant/busy for
   // offsets 0..2+PULSE, gate high for offsets 2..1+PULSE, done at 2+PULSE,
   // and the next grant may happen no earlier than S+4+PULSE.
   int               m_edge = 0;
   int               m_start = -1;
   int               m_next_arb = 0;
   int               m_ptr = 0;
   logic [NREQ-1:0]  m_owner = '0;
   logic [WIDTH-1:0] m_data = '0;
   logic [NREQ-1:0]  exp_grant, exp_done;
   logic [WIDTH-1:0] exp_d;
   logic             exp_c, exp_busy;

   logic [WIDTH-1:0] latch_q = '0;
   logic [WIDTH-1:0] d_hist [3];
   logic             c_hist [3];
   int               hist_n = 0;
   logic             rst_seen = 1'b0;

   always #5 clk = ~clk;

   latch_write_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .PULSE (PULSE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .wdata   (wdata),
      .grant   (grant),
      .done    (done),
      .latch_d (latch_d),
      .latch_c (latch_c),
      .busy    (busy)
   );

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ*WIDTH-1:0] pack4(input logic [7:0] d0, input logic [7:0] d1,
                                                   input logic [7:0] d2, input logic [7:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic modelEdge(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] wd, input logic rst_v);
      int w;
      int off;
      if (!rst_v) begin
         m_ptr      = 0;
         m_start    = -1;
         m_next_arb = m_edge + 1;
         m_data     = '0;
      end else begin
         if (m_start >= 0 && (m_edge - m_start) >= 3 + PULSE) m_start = -1;
         if (m_start < 0 && m_edge >= m_next_arb && r != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               if (w < 0 && ((r >> ((m_ptr + k) % NREQ)) & 1) != 0) w = (m_ptr + k) % NREQ;
            end
            m_owner    = NREQ'(1) << w;
            m_data     = WIDTH'(wd >> (w * WIDTH));
            m_start    = m_edge;
            m_next_arb = m_edge + 4 + PULSE;
            m_ptr      = (w + 1) % NREQ;
         end
      end
      off = m_edge - m_start;
      if (m_start >= 0) begin
         exp_grant = m_owner;
         exp_busy  = 1'b1;
         exp_c     = (off >= 2) && (off <= 1 + PULSE);
         exp_done  = (off == 2 + PULSE) ? m_owner : '0;
      end else begin
         exp_grant = '0;
         exp_busy  = 1'b0;
         exp_c     = 1'b0;
         exp_done  = '0;
      end
      exp_d = m_data;
      m_edge++;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] wd, input logic rst_v);
      req   = r;
      wdata = wd;
      rst_n = rst_v;
      modelEdge(r, wd, rst_v);
      @(posedge clk);
      #1;
      if (latch_c === 1'b1) latch_q = latch_d;
      rst_seen = !rst_v;
   endtask

   task automatic checkOutput(input string tag);
      compare({tag, ".grant"},   32'(grant),   32'(exp_grant));
      compare({tag, ".done"},    32'(done),    32'(exp_done));
      compare({tag, ".latch_d"}, 32'(latch_d), 32'(exp_d));
      compare({tag, ".latch_c"}, 32'(latch_c), 32'(exp_c));
      compare({tag, ".busy"},    32'(busy),    32'(exp_busy));
      if (exp_done != '0) compare({tag, ".latch_q"}, 32'(latch_q), 32'(m_data));
      if (rst_seen) hist_n = 0;
      d_hist[2] = d_hist[1]; d_hist[1] = d_hist[0]; d_hist[0] = latch_d;
      c_hist[2] = c_hist[1]; c_hist[1] = c_hist[0]; c_hist[0] = latch_c;
      if (hist_n < 3) hist_n++;
      if (hist_n >= 2 && c_hist[0])
         compare({tag, ".stable_gate"}, 32'(d_hist[0]), 32'(d_hist[1]));
      if (hist_n >= 3 && c_hist[0] && !c_hist[1])
         compare({tag, ".stable_pre_rise"}, 32'(d_hist[1]), 32'(d_hist[2]));
      if (hist_n >= 2 && !c_hist[0] && c_hist[1])
         compare({tag, ".stable_fall"}, 32'(d_hist[0]), 32'(d_hist[1]));
      if (hist_n >= 3 && !c_hist[0] && !c_hist[1] && c_hist[2])
         compare({tag, ".stable_post_fall"}, 32'(d_hist[0]), 32'(d_hist[1]));
   endtask

   // Directed scenarios followed by a random soak.
   initial begin
      int rr_idx [8];
      int rr_cyc [8];
      int rr_n;
      logic [NREQ-1:0] prev_g;
      int done2_seen;
      int regrant2;

      for (int i = 0; i < 3; i++) begin d_hist[i] = '0; c_hist[i] = 1'b0; end

      // Reset
      applyStimulus('0, '0, 1'b0);
      applyStimulus('0, '0, 1'b0);
      checkOutput("reset");

      // Single write from requester 1
      for (int i = 0; i < 7; i++) begin
         applyStimulus((i == 0) ? 4'b0010 : 4'b0000, pack4(8'h11, 8'hA5, 8'h22, 8'h33), 1'b1);
         checkOutput("single");
         if (i == 0) compare("single.grant_first", 32'(grant), 32'h2);
         if (i >= 0 && i <= 4) compare("single.latch_d_held", 32'(latch_d), 32'hA5);
         if (i == 2 || i == 3) compare("single.gate_high", 32'(latch_c), 32'h1);
         if (i == 4) compare("single.done1", 32'(done), 32'h2);
         if (i == 4) compare("single.latch_q", 32'(latch_q), 32'hA5);
      end

      // Round robin with all requesters asserted, starting from a fresh pointer
      applyStimulus('0, '0, 1'b0);
      checkOutput("rr_reset");
      rr_n = 0;
      prev_g = '0;
      for (int i = 0; i < 34; i++) begin
         applyStimulus((i < 26) ? 4'b1111 : 4'b0000, pack4(8'h10, 8'h11, 8'h12, 8'h13), 1'b1);
         checkOutput("rr");
         if (grant != '0 && prev_g == '0 && rr_n < 8) begin
            for (int k = 0; k < NREQ; k++) if (grant[k]) rr_idx[rr_n] = k;
            rr_cyc[rr_n] = i;
            rr_n++;
         end
         prev_g = grant;
      end
      compare("rr.grant_count", 32'(rr_n), 32'd5);
      for (int k = 0; k < rr_n && k < 5; k++) begin
         compare($sformatf("rr.order%0d", k), 32'(rr_idx[k]), 32'(k % NREQ));
         compare($sformatf("rr.cycle%0d", k), 32'(rr_cyc[k]), 32'(6 * k));
      end

      // Data is sampled at grant only
      for (int i = 0; i < 7; i++) begin
         applyStimulus((i == 0) ? 4'b0001 : 4'b0000,
                       (i == 0) ? pack4(8'h3C, 8'h00, 8'h00, 8'h00) : pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1);
         checkOutput("sample");
         compare("sample.latch_d", 32'(latch_d), 32'h3C);
      end
      compare("sample.latch_q", 32'(latch_q), 32'h3C);

      // Request withdrawn during the gate pulse
      done2_seen = 0;
      regrant2 = 0;
      prev_g = '0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus((i < 2) ? 4'b0100 : 4'b0000, pack4(8'h01, 8'h02, 8'h5A, 8'h04), 1'b1);
         checkOutput("withdraw");
         if (done == 4'b0100) done2_seen++;
         if (grant[2] && !prev_g[2] && i > 0) regrant2++;
         prev_g = grant;
      end
      compare("withdraw.done_pulses", 32'(done2_seen), 32'd1);
      compare("withdraw.regrant", 32'(regrant2), 32'd0);

      // Reset in the middle of the gate pulse, then pointer must be back at 0
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0010, pack4(8'h01, 8'h77, 8'h03, 8'h04), 1'b1);
         checkOutput("midrst_pre");
      end
      compare("midrst.gate_high", 32'(latch_c), 32'h1);
      applyStimulus(4'b0010, pack4(8'h01, 8'h77, 8'h03, 8'h04), 1'b0);
      checkOutput("midrst");
      compare("midrst.latch_c", 32'(latch_c), 32'h0);
      compare("midrst.grant", 32'(grant), 32'h0);
      compare("midrst.busy", 32'(busy), 32'h0);
      compare("midrst.latch_d", 32'(latch_d), 32'h0);
      compare("midrst.done", 32'(done), 32'h0);
      applyStimulus(4'b0101, pack4(8'hC1, 8'h00, 8'hC3, 8'h00), 1'b1);
      checkOutput("midrst_post");
      compare("midrst.grant_after", 32'(grant), 32'h1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, '0, 1'b1);
         checkOutput("midrst_drain");
      end

      // Random soak
      for (int i = 0; i < 200; i++) begin
         applyStimulus(NREQ'($urandom_range(0, 15)), (NREQ*WIDTH)'($urandom), 1'b1);
         checkOutput("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
